hs4_pipe_ctrl: RTL and testbench

Parametrised, clocked four-phase (return-to-zero) handshake pipeline controller with DEPTH latch stages of WIDTH-bit data. Each stage's acknowledge is a registered generalised C-element (set = upstream request and stage empty; reset = upstream request low; hold otherwise), the synchronous multi-stage successor to the single REack/Rreq controller. It sits between a four-phase producer and a four-phase consumer in the controller datapath and provides buffering, back-pressure and an occupancy count.

---
 rtl/hs4_pkg.sv | 26 ++
 rtl/hs4_stage.sv | 61 ++++++
 rtl/hs4_pipe_ctrl.sv | 98 +++++++++
 tb/tb_hs4_pipe_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs4_pkg.sv
// Shared types and helpers for the hs4 four-phase handshake pipeline.
package hs4_pkg;

  // Upper bound on DEPTH that the occupancy popcount can cover.
  localparam int unsigned MAX_DEPTH = 64;

  typedef struct packed {
    logic full;
    logic rack;
    logic lreq;
  } hs4_stage_t;

  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n += {31'b0, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/hs4_stage.sv
// One four-phase pipeline stage: a registered C-element ack to upstream, a request
// to downstream, and a WIDTH-bit data register loaded on capture.
module hs4_stage
  import hs4_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_req_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_ack_i,
  output hs4_stage_t       st_o,
  output logic [WIDTH-1:0] data_o
);

  hs4_stage_t       st_q, st_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    // NOTE: hold-by-default assignments come first so every path assigns each
    // next-state bit; a missed branch would otherwise infer a latch.
    st_d   = st_q;
    data_d = data_q;

    // Upstream side: capture only into an empty stage, release once req drops.
    if (up_req_i && !st_q.rack && !st_q.full) begin
      data_d    = up_data_i;
      st_d.full = 1'b1;
      st_d.rack = 1'b1;
    end else if (!up_req_i && st_q.rack) begin
      st_d.rack = 1'b0;
    end

    // Downstream side: a new request waits for the previous ack to return low.
    if (st_q.full && !st_q.lreq && !dn_ack_i) begin
      st_d.lreq = 1'b1;
    end else if (st_q.lreq && dn_ack_i) begin
      st_d.lreq = 1'b0;
      st_d.full = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= '0;
      // NOTE: the data register is reset too, because out_data must read 0
      // straight out of reset rather than whatever the flops powered up with.
      data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so all flops update from the same
      // pre-edge values regardless of statement order.
      st_q   <= st_d;
      data_q <= data_d;
    end
  end

  assign st_o   = st_q;
  assign data_o = data_q;

endmodule

// File: rtl/hs4_pipe_ctrl.sv
// DEPTH-stage four-phase handshake pipeline with occupancy count. Define
// HS4_PROTO_CHECK_EN to build the sticky producer/consumer protocol checker.
module hs4_pipe_ctrl
  import hs4_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_req,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ack,
  output logic                          out_req,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ack,
  output logic [lvl_width(DEPTH)-1:0]   level,
  output logic                          proto_err
);

  localparam int unsigned LVL_W = lvl_width(DEPTH);

  // Link k sits between stage k-1 and stage k; link 0 is the producer side and
  // link DEPTH the consumer side.
  logic [DEPTH:0]   req_link;
  logic [DEPTH:0]   ack_link;
  logic [WIDTH-1:0] data_link [DEPTH+1];
  hs4_stage_t       st [DEPTH];
  logic [DEPTH-1:0] full;
  logic [MAX_DEPTH-1:0] full_ext;

  assign req_link[0]     = in_req;
  assign data_link[0]    = in_data;
  assign ack_link[DEPTH] = out_ack;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    hs4_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_req_i (req_link[i]),
      .up_data_i(data_link[i]),
      .dn_ack_i (ack_link[i+1]),
      .st_o     (st[i]),
      .data_o   (data_link[i+1])
    );

    assign req_link[i+1] = st[i].lreq;
    assign ack_link[i]   = st[i].rack;
    assign full[i]       = st[i].full;
  end

  assign in_ack   = ack_link[0];
  assign out_req  = req_link[DEPTH];
  assign out_data = data_link[DEPTH];

  always_comb begin
    full_ext              = '0;
    full_ext[DEPTH-1:0]   = full;
  end

  assign level = LVL_W'(popcount(full_ext));

`ifdef HS4_PROTO_CHECK_EN
  logic             in_req_q;
  logic [WIDTH-1:0] in_data_q;
  logic             out_ack_q;
  logic             err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (in_req_q && !in_req && !in_ack)                          err_d = 1'b1;
    if (in_req_q && in_req && !in_ack && (in_data != in_data_q)) err_d = 1'b1;
    if (!out_ack_q && out_ack && !out_req)                       err_d = 1'b1;
    if (out_ack_q && !out_ack && out_req)                        err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_req_q  <= 1'b0;
      in_data_q <= '0;
      out_ack_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      in_req_q  <= in_req;
      in_data_q <= in_data;
      out_ack_q <= out_ack;
      err_q     <= err_d;
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_hs4_pipe_ctrl.sv
// Self-checking bench for hs4_pipe_ctrl: directed handshake scenarios plus a
// randomized producer/consumer run checked against an in-order token FIFO model.
module tb_hs4_pipe_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int N_RND = 300;

`ifdef HS4_PROTO_CHECK_EN
  localparam logic PROTO_ON = 1'b1;
`else
  localparam logic PROTO_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_req;
  logic [WIDTH-1:0] in_data;
  logic             in_ack;
  logic             out_req;
  logic [WIDTH-1:0] out_data;
  logic             out_ack;
  logic [LVL_W-1:0] level;
  logic             proto_err;

  int checks   = 0;
  int failures = 0;
  int received = 0;

  logic [WIDTH-1:0] to_send [$];
  logic [WIDTH-1:0] exp_q   [$];

  hs4_pipe_ctrl #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_req   (in_req),
    .in_data  (in_data),
    .in_ack   (in_ack),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .level    (level),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit chance(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  // One negedge worth of four-phase producer and consumer behaviour.
  task automatic service(input int p_pct, input int c_pct);
    if (out_req && !out_ack) begin
      if (chance(c_pct)) begin
        check("tok_expected", {31'b0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) check("tok_order", out_data, exp_q.pop_front());
        received++;
        out_ack = 1'b1;
      end
    end else if (!out_req && out_ack) begin
      if (chance(c_pct)) out_ack = 1'b0;
    end

    if (in_req && in_ack) begin
      if (chance(p_pct)) in_req = 1'b0;
    end else if (!in_req && !in_ack && to_send.size() != 0) begin
      if (chance(p_pct)) begin
        in_data = to_send.pop_front();
        exp_q.push_back(in_data);
        in_req = 1'b1;
      end
    end
  endtask

  task automatic drain(input string tag, input int budget, input int p_pct,
                       input int c_pct, input bit watch_ack);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!(to_send.size() == 0 && exp_q.size() == 0 && !in_req && !in_ack &&
             !out_req && !out_ack) && n < budget) begin
      if (watch_ack && !seen && in_ack) begin
        seen = 1'b1;
        check("bp_ack_after_out", {31'b0, received >= 1}, 1);
      end
      service(p_pct, c_pct);
      @(negedge clk);
      check("level_bound", {31'b0, level <= LVL_W'(DEPTH)}, 1);
      n++;
    end
    check(tag, {31'b0, n < budget}, 1);
  endtask

  initial begin
    rst     = 1'b1;
    in_req  = 1'b0;
    in_data = '0;
    out_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ack",    in_ack,    0);
    check("rst_out_req",   out_req,   0);
    check("rst_out_data",  out_data,  0);
    check("rst_level",     level,     0);
    check("rst_proto_err", proto_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single token, edge-by-edge through both stages.
    in_req  = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    check("st_in_ack_e1",  in_ack,  1);
    check("st_level_e1",   level,   1);
    check("st_out_req_e1", out_req, 0);
    in_req = 1'b0;
    @(negedge clk);
    check("st_in_ack_e2",  in_ack,  0);
    check("st_level_e2",   level,   1);
    @(negedge clk);
    check("st_out_req_e3", out_req, 0);
    check("st_level_e3",   level,   2);
    @(negedge clk);
    check("st_out_req_e4",  out_req,  1);
    check("st_out_data_e4", out_data, 8'hA5);
    check("st_level_e4",    level,    1);
    out_ack = 1'b1;
    @(negedge clk);
    check("st_out_req_e5", out_req, 0);
    check("st_level_e5",   level,   0);
    out_ack = 1'b0;
    @(negedge clk);

    // Back-pressure: consumer stalled, third token must wait.
    received = 0;
    to_send  = '{8'h01, 8'h02, 8'h03};
    repeat (12) begin
      service(100, 0);
      @(negedge clk);
    end
    check("bp_level",    level,    2);
    check("bp_in_ack",   in_ack,   0);
    check("bp_out_req",  out_req,  1);
    check("bp_out_data", out_data, 8'h01);
    drain("bp_drain_done", 100, 100, 100, 1'b1);
    check("bp_count",     received, 3);
    check("bp_level_end", level,    0);
    check("bp_req_end",   out_req,  0);

    // Stage 0 releases its ack and hands off on the same edge.
    in_req  = 1'b1;
    in_data = 8'h5A;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    check("ov_ack_e1", in_ack, 1);
    repeat (2) @(negedge clk);
    check("ov_ack_e3", in_ack, 1);
    check("ov_lvl_e3", level,  2);
    in_req = 1'b0;
    @(negedge clk);
    check("ov_ack_e4",  in_ack,  0);
    check("ov_lvl_e4",  level,   1);
    check("ov_oreq_e4", out_req, 1);
    in_req  = 1'b1;
    in_data = 8'h6B;
    exp_q.push_back(8'h6B);
    @(negedge clk);
    check("ov_ack_e5", in_ack, 1);
    check("ov_lvl_e5", level,  2);
    drain("ov_drain_done", 100, 100, 100, 1'b0);

    // Randomized producer/consumer timing against the FIFO model.
    received = 0;
    for (int i = 0; i < N_RND; i++) to_send.push_back(WIDTH'($urandom));
    drain("rnd_drain_done", 20000, 60, 50, 1'b0);
    check("rnd_count",     received,  N_RND);
    check("rnd_level",     level,     0);
    check("rnd_proto_err", proto_err, 0);

    // Request withdrawn before it was acknowledged.
    to_send = '{8'h11, 8'h22};
    repeat (12) begin
      service(100, 0);
      @(negedge clk);
    end
    in_req  = 1'b1;
    in_data = 8'h33;
    repeat (2) @(negedge clk);
    check("pe_in_ack", in_ack,    0);
    check("pe_before", proto_err, 0);
    in_req = 1'b0;
    @(negedge clk);
    check("pe_set",  proto_err, PROTO_ON);
    repeat (3) @(negedge clk);
    check("pe_held", proto_err, PROTO_ON);
    check("pe_lvl",  level,     2);

    // Asynchronous reset mid-run, observed before the next clock edge.
    #2 rst = 1'b1;
    #1;
    check("arst_in_ack",    in_ack,    0);
    check("arst_out_req",   out_req,   0);
    check("arst_out_data",  out_data,  0);
    check("arst_level",     level,     0);
    check("arst_proto_err", proto_err, 0);
    to_send.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_req  = 1'b1;
    in_data = 8'h77;
    exp_q.push_back(8'h77);
    @(negedge clk);
    check("arst_fresh_ack", in_ack, 1);
    drain("arst_drain_done", 100, 100, 100, 1'b0);
    check("arst_proto_end", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
